// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN      = 2'd0,
    DEB_PRESS = 2'd1,
    HELD      = 2'd2
  } state_t;

  localparam logic [3:0] COL_RESET = 4'b0001;

  // One-hot (or multi-hot) to 2-bit index; the lowest set bit wins.
  function automatic logic [1:0] onehot_to_idx(input logic [3:0] v);
    logic [1:0] idx;
    idx = '0;
    for (int unsigned i = 4; i > 0; i--) begin
      if (v[i-1]) idx = 2'(i - 1);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for asynchronous level inputs.
module sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // Two register stages to resolve metastability.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with press/release debounce and one-shot key events.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 4,
  parameter int unsigned DEBOUNCE_CNT = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held
);

  localparam int unsigned TW = $clog2(SCAN_DIV);

  state_t          r_state;
  state_t          w_state_next;
  logic [TW-1:0]   r_tick_cnt;
  logic [3:0]      r_deb_cnt;
  logic [3:0]      w_deb_next;
  logic [1:0]      r_row_idx;
  logic [1:0]      r_col_idx;
  logic [3:0]      w_row_s;
  logic            w_tick;
  logic            w_any;
  logic            w_hit;
  logic            w_deb_done;
  logic            w_latch;
  logic            w_accept;
  logic            w_release;
  logic            w_rotate;
  logic [3:0]      w_code;

  sync2 #(.WIDTH(4)) u_row_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (row),
    .o_q   (w_row_s)
  );

  assign w_tick     = (r_tick_cnt == TW'(SCAN_DIV - 1));
  assign w_any      = |w_row_s;
  assign w_hit      = w_row_s[r_row_idx];
  assign w_deb_done = ((r_deb_cnt + 4'd1) == 4'(DEBOUNCE_CNT));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= SCAN;
    else        r_state <= w_state_next;
  end

  // Next-state decision, evaluated only on scan ticks.
  always_comb begin
    w_state_next = r_state;
    if (w_tick) begin
      unique case (r_state)
        SCAN:      if (w_any) w_state_next = (DEBOUNCE_CNT == 1) ? HELD : DEB_PRESS;
        DEB_PRESS: if (!w_hit) w_state_next = SCAN;
                   else if (w_deb_done) w_state_next = HELD;
        HELD:      if (!w_hit && w_deb_done) w_state_next = SCAN;
        default:   w_state_next = SCAN;
      endcase
    end
  end

  // Action strobes and debounce counter update for the current state.
  // The single counter serves both the press and the release debounce; it is
  // zeroed on accept so the release count starts clean.
  always_comb begin
    w_latch    = 1'b0;
    w_accept   = 1'b0;
    w_release  = 1'b0;
    w_rotate   = 1'b0;
    w_deb_next = r_deb_cnt;
    w_code     = {r_row_idx, r_col_idx};
    if (r_state == SCAN) w_code = {onehot_to_idx(w_row_s), onehot_to_idx(col)};
    if (w_tick) begin
      unique case (r_state)
        SCAN: begin
          if (w_any) begin
            w_latch    = 1'b1;
            w_accept   = (DEBOUNCE_CNT == 1);
            w_deb_next = (DEBOUNCE_CNT == 1) ? 4'd0 : 4'd1;
          end else begin
            w_rotate = 1'b1;
          end
        end
        DEB_PRESS: begin
          if (w_hit) begin
            w_accept   = w_deb_done;
            w_deb_next = w_deb_done ? 4'd0 : r_deb_cnt + 4'd1;
          end else begin
            w_rotate   = 1'b1;
            w_deb_next = 4'd0;
          end
        end
        HELD: begin
          if (w_hit) begin
            w_deb_next = 4'd0;
          end else begin
            w_release  = w_deb_done;
            w_rotate   = w_deb_done;
            w_deb_next = w_deb_done ? 4'd0 : r_deb_cnt + 4'd1;
          end
        end
        default: w_deb_next = 4'd0;
      endcase
    end
  end

  // Datapath: dwell counter, column drive, latched key and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_cnt <= '0;
      r_deb_cnt  <= '0;
      r_row_idx  <= '0;
      r_col_idx  <= '0;
      col        <= COL_RESET;
      key_valid  <= 1'b0;
      key_code   <= '0;
      key_held   <= 1'b0;
    end else begin
      r_tick_cnt <= (w_tick || w_rotate) ? '0 : r_tick_cnt + TW'(1);
      r_deb_cnt  <= w_deb_next;
      if (w_rotate) col <= {col[2:0], col[3]};
      if (w_latch) begin
        r_row_idx <= onehot_to_idx(w_row_s);
        r_col_idx <= onehot_to_idx(col);
      end
      key_valid <= w_accept;
      if (w_accept) key_code <= w_code;
      if (w_accept)       key_held <= 1'b1;
      else if (w_release) key_held <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed and randomized checks of the keypad scanner against a physical keypad model.
module tb_keypad_scanner;

  localparam int LAT = 2 + 4 * 4 + 4 * (3 - 1) + 1;  // 27 clocks
  localparam int REL = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] row_w;
  logic [3:0] col;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_held;

  logic [15:0] keys;
  logic        ovr_en;
  logic [3:0]  ovr_val;

  int n_checks = 0;
  int n_fail   = 0;
  int pulse_cnt = 0;
  int stuck_cnt = 0;
  logic prev_v = 1'b0;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row       (row_w),
    .col       (col),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  // Keypad matrix: row r is high when a pressed key (r,c) sits on a driven column c.
  always_comb begin
    row_w = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && col[c]) row_w[r] = 1'b1;
    if (ovr_en) row_w = ovr_val;
  end

  // Event monitor, sampled shortly after each rising edge.
  always begin
    @(posedge clk);
    #2;
    if (key_valid === 1'b1) pulse_cnt++;
    if (key_valid === 1'b1 && prev_v === 1'b1) stuck_cnt++;
    prev_v = key_valid;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input string tag, input int code, input logic [3:0] exp_col);
    int n = 0;
    while (key_valid !== 1'b1 && n < LAT) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".valid"}, 16'(key_valid), 16'd1);
    check({tag, ".code"},  16'(key_code), 16'(code));
    check({tag, ".held"},  16'(key_held), 16'd1);
    check({tag, ".col"},   16'(col), 16'(exp_col));
    @(negedge clk);
    check({tag, ".pulse1"}, 16'(key_valid), 16'd0);
  endtask

  task automatic wait_release(input string tag, input logic [3:0] exp_col);
    int n = 0;
    while (key_held !== 1'b0 && n < REL) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".rel"},    16'(key_held), 16'd0);
    check({tag, ".relcol"}, 16'(col), 16'(exp_col));
  endtask

  task automatic wait_col_enter(input logic [3:0] target);
    int n = 0;
    while (col === target && n < 40) begin @(negedge clk); n++; end
    while (col !== target && n < 40) begin @(negedge clk); n++; end
    check("col_enter", 16'(col), 16'(target));
  endtask

  initial begin
    int p0, r, c, k;
    logic [3:0] nxt;

    // Reset with all rows forced high.
    rst_n = 1'b0; keys = '0; ovr_en = 1'b1; ovr_val = 4'hF;
    tick(3);
    check("rst.col",   16'(col), 16'h1);
    check("rst.valid", 16'(key_valid), 16'd0);
    check("rst.code",  16'(key_code), 16'd0);
    check("rst.held",  16'(key_held), 16'd0);
    ovr_en = 1'b0;
    rst_n = 1'b1;
    tick(3); check("scan.dwell", 16'(col), 16'h1);
    tick(1); check("scan.c1", 16'(col), 16'h2);
    tick(4); check("scan.c2", 16'(col), 16'h4);
    tick(4); check("scan.c3", 16'(col), 16'h8);
    tick(4); check("scan.c0", 16'(col), 16'h1);

    // Clean press of key 6.
    keys = 16'(1) << 6;
    wait_valid("k6", 6, 4'b0100);
    p0 = pulse_cnt;
    tick(20);
    check("k6.once", 16'(pulse_cnt - p0), 16'd0);
    check("k6.hold", 16'(key_held), 16'd1);
    keys = '0;
    wait_release("k6", 4'b1000);

    // One-tick bounce on key 9, then a stable press.
    wait_col_enter(4'b0010);
    p0 = pulse_cnt;
    keys = 16'(1) << 9;
    tick(4);
    check("b9.frozen", 16'(col), 16'h2);
    keys = '0;
    tick(4);
    check("b9.resume", 16'(col), 16'h4);
    tick(8);
    check("b9.noevt", 16'(pulse_cnt - p0), 16'd0);
    keys = 16'(1) << 9;
    wait_valid("k9", 9, 4'b0010);
    keys = '0;
    wait_release("k9", 4'b0100);

    // Release glitch of two ticks on key F.
    keys = 16'(1) << 15;
    wait_valid("kF", 15, 4'b1000);
    tick(3);
    p0 = pulse_cnt;
    keys = '0;
    tick(8);
    keys = 16'(1) << 15;
    tick(20);
    check("kF.held",  16'(key_held), 16'd1);
    check("kF.noevt", 16'(pulse_cnt - p0), 16'd0);
    check("kF.col",   16'(col), 16'h8);
    keys = '0;
    wait_release("kF", 4'b0001);

    // Two rows in column 0; lowest row wins. Extra keys while held are ignored.
    keys = (16'(1) << 4) | (16'(1) << 12);
    wait_valid("k4", 4, 4'b0001);
    p0 = pulse_cnt;
    keys = keys | (16'(1) << 8) | (16'(1) << 5);
    tick(24);
    check("k4.noevt", 16'(pulse_cnt - p0), 16'd0);
    check("k4.held",  16'(key_held), 16'd1);
    keys = '0;
    wait_release("k4", 4'b0010);

    // Reset during press debounce of key 7.
    wait_col_enter(4'b1000);
    p0 = pulse_cnt;
    keys = 16'(1) << 7;
    tick(9);
    check("mr.frozen", 16'(col), 16'h8);
    rst_n = 1'b0;
    #1;
    check("mr.col",   16'(col), 16'h1);
    check("mr.valid", 16'(key_valid), 16'd0);
    check("mr.code",  16'(key_code), 16'd0);
    check("mr.held",  16'(key_held), 16'd0);
    tick(2);
    check("mr.noevt", 16'(pulse_cnt - p0), 16'd0);
    rst_n = 1'b1;
    wait_valid("k7", 7, 4'b1000);
    keys = '0;
    wait_release("k7", 4'b0001);

    // Random single-key presses: code = row*4 + col, scan resumes at the next column.
    for (int i = 0; i < 8; i++) begin
      r = $urandom_range(0, 3);
      c = $urandom_range(0, 3);
      k = r * 4 + c;
      keys = 16'(1) << k;
      wait_valid("rnd", k, 4'(1 << c));
      p0 = pulse_cnt;
      tick($urandom_range(0, 20));
      check("rnd.once", 16'(pulse_cnt - p0), 16'd0);
      keys = '0;
      nxt = 4'(1 << ((c + 1) % 4));
      wait_release("rnd", nxt);
      tick($urandom_range(0, 10));
    end

    tick(2);
    check("pulse.width", 16'(stuck_cnt), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
